// File: rtl/piso_shift_reg_param_if.sv
// Load/serial bundle for piso_shift_reg_param: the source drives load, p_in
// and shift_en, and the shifter returns the handshake, the serial line and the flags.
interface piso_shift_reg_param_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] p_in;
  logic             shift_en;
  logic             load_ready;
  logic             s_out;
  logic             s_valid;
  logic             s_last;
  logic             busy;
  logic             overrun;

  modport master (
    output load,
    output p_in,
    output shift_en,
    input  load_ready,
    input  s_out,
    input  s_valid,
    input  s_last,
    input  busy,
    input  overrun
  );

  modport slave (
    input  load,
    input  p_in,
    input  shift_en,
    output load_ready,
    output s_out,
    output s_valid,
    output s_last,
    output busy,
    output overrun
  );
endinterface

// File: rtl/piso_shift_reg_param.sv
// Parametrised parallel-in serial-out shifter with a ready/valid load, bit-rate pacing,
// gapless reload on the last bit, last-bit and overrun flags, and a programmable idle level.
module piso_shift_reg_param #(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  piso_shift_reg_param_if.slave     bus
);

  localparam int                CNT_W    = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_overrun;
  logic             w_overrun_nxt;

  logic             w_at_last;
  logic             w_load_ready;
  logic             w_accept;
  logic             w_s_valid;
  logic [WIDTH-1:0] w_shreg_shifted;

  // The last bit may hand over to a new word only on an edge that actually advances it.
  assign w_at_last    = (r_cnt == LAST_CNT);
  assign w_load_ready = (r_state == S_IDLE) ||
                        ((r_state == S_SHIFT) && bus.shift_en && w_at_last);
  assign w_accept     = bus.load && w_load_ready;

  // Move the next bit toward the output end; the fill bit is never observed.
  assign w_shreg_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                     : {1'b0, r_shreg[WIDTH-1:1]};

  // NOTE: every next-state signal gets a hold default before the case, so no path
  // through this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_cnt_nxt     = r_cnt;
    w_overrun_nxt = bus.load && !w_load_ready;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg_nxt = bus.p_in;
          w_cnt_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (bus.shift_en) begin
          if (!w_at_last) begin
            w_shreg_nxt = w_shreg_shifted;
            w_cnt_nxt   = r_cnt + 1'b1;
          end else if (w_accept) begin
            w_shreg_nxt = bus.p_in;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: reset is sampled synchronously here, and all state is updated with
  // non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_cnt     <= w_cnt_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Serial outputs come only from registers, so no input reaches s_out combinationally.
  assign w_s_valid      = (r_state == S_SHIFT);
  assign bus.s_valid    = w_s_valid;
  assign bus.busy       = w_s_valid;
  assign bus.s_out      = w_s_valid ? (MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0]) : IDLE_LEVEL;
  assign bus.s_last     = w_s_valid && w_at_last;
  assign bus.load_ready = w_load_ready;
  assign bus.overrun    = r_overrun;

  a_cnt_in_range: assert property (@(posedge clk) disable iff (rst)
    r_cnt <= LAST_CNT);

  a_last_needs_valid: assert property (@(posedge clk) disable iff (rst)
    bus.s_last |-> bus.s_valid);

  a_overrun_after_reject: assert property (@(posedge clk) disable iff (rst)
    (bus.load && !w_load_ready) |=> r_overrun);

endmodule
